// File: rtl/param_crypto_core.sv
// Iterated XOR/rotate block cipher: one round per clock, ROUNDS cycles start-to-done.
// Start is only honoured in IDLE; abort wins over start and over the final round.
module param_crypto_core #(
  parameter int DATA_W = 64,
  parameter int ROUNDS = 10,
  parameter int ROT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [2*DATA_W-1:0]   key,
  output logic [DATA_W-1:0]     data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int R = ROT % DATA_W;
  localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  fsm_t                fsm;
  logic [DATA_W-1:0]   s;
  logic [2*DATA_W-1:0] key_q;
  logic                mode_q;
  logic [7:0]          rc;

  logic [DATA_W-1:0]   rk;
  logic [DATA_W-1:0]   enc_t;
  logic [DATA_W-1:0]   enc_nxt;
  logic [DATA_W-1:0]   dec_nxt;
  logic [DATA_W-1:0]   round_nxt;
  logic                last_round;

  // A shift by DATA_W yields zero, so R == 0 degenerates to the identity.
  always_comb begin
    rk         = (rc[0] ? key_q[DATA_W-1:0] : key_q[2*DATA_W-1:DATA_W]) ^ DATA_W'(rc);
    enc_t      = s ^ rk;
    enc_nxt    = (enc_t << R) | (enc_t >> (DATA_W - R));
    dec_nxt    = ((s >> R) | (s << (DATA_W - R))) ^ rk;
    round_nxt  = mode_q ? dec_nxt : enc_nxt;
    last_round = mode_q ? (rc == 8'd0) : (rc == LAST_IDX);
  end

  assign busy = (fsm == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      s        <= '0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      rc       <= '0;
      data_out <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (fsm == IDLE) begin
        if (abort) begin
          data_out <= '0;
        end else if (start) begin
          if (key == '0) begin
            err <= 1'b1;
          end else begin
            fsm    <= RUN;
            s      <= data_in;
            key_q  <= key;
            mode_q <= mode;
            rc     <= mode ? LAST_IDX : 8'd0;
          end
        end
      end else begin
        if (abort || last_round) begin
          fsm      <= IDLE;
          s        <= '0;
          key_q    <= '0;
          rc       <= '0;
          data_out <= abort ? '0 : round_nxt;
          done     <= !abort;
        end else begin
          s  <= round_nxt;
          rc <= mode_q ? rc - 8'd1 : rc + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_crypto_core.sv
// Randomised bench for param_crypto_core against a round-by-round reference model.
module tb_param_crypto_core;

  localparam int W  = 64;
  localparam int NR = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [2*W-1:0] key = '0;
  logic [W-1:0]  data_out;
  logic          busy, done, err;

  logic          s_start = 1'b0, s_mode = 1'b0, s_abort = 1'b0;
  logic [7:0]    s_data_in = '0;
  logic [15:0]   s_key = '0;
  logic [7:0]    s_data_out;
  logic          s_busy, s_done, s_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_crypto_core u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .data_in(data_in), .key(key), .data_out(data_out),
    .busy(busy), .done(done), .err(err)
  );

  param_crypto_core #(.DATA_W(8), .ROUNDS(1), .ROT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .abort(s_abort),
    .data_in(s_data_in), .key(s_key), .data_out(s_data_out),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_cipher(input logic [W-1:0] d, input logic [2*W-1:0] k,
                                               input bit dec);
    logic [W-1:0] x;
    logic [W-1:0] rk;
    int i;
    x = d;
    for (int n = 0; n < NR; n++) begin
      i  = dec ? NR - 1 - n : n;
      rk = ((i % 2) == 1 ? k[W-1:0] : k[2*W-1:W]) ^ W'(i);
      if (!dec) begin
        x = x ^ rk;
        x = {x[W-2:0], x[W-1]};
      end else begin
        x = {x[0], x[W-1:1]} ^ rk;
      end
    end
    return x;
  endfunction

  function automatic logic [2*W-1:0] rand_key();
    logic [2*W-1:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    if (k == '0) k = 128'h1;
    return k;
  endfunction

  // Runs one operation; optionally pokes start mid-run, which must be ignored.
  task automatic do_op(input string tag, input bit m, input logic [W-1:0] d,
                       input logic [2*W-1:0] k, input bit poke, output logic [W-1:0] res);
    int cyc;
    int busy_cnt;
    int err_cnt;
    @(negedge clk);
    start = 1'b1; mode = m; data_in = d; key = k;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_cnt = 0; err_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (poke && cyc == 4) begin
        start = 1'b1; mode = ~m; data_in = ~d;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    res = data_out;
    chk({tag, "_latency"}, cyc, NR);
    chk({tag, "_busy_cycles"}, busy_cnt, NR);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_no_err"}, err_cnt, 0);
    chk({tag, "_result"}, data_out, ref_cipher(d, k, m));
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic count_done(input string tag, input int ncyc);
    int seen;
    seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  logic [W-1:0]   pt, ct, rt;
  logic [2*W-1:0] k;

  initial begin
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_dout", data_out, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Small configuration: known vectors, one-cycle latency.
    @(negedge clk);
    s_start = 1'b1; s_mode = 1'b0; s_data_in = 8'h0F; s_key = 16'h0155;
    @(negedge clk);
    s_start = 1'b0;
    chk("small_enc_busy", s_busy, 1'b1);
    @(negedge clk);
    chk("small_enc_done", s_done, 1'b1);
    chk("small_enc_dout", s_data_out, 8'h1C);
    s_start = 1'b1; s_mode = 1'b1; s_data_in = 8'h1C;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    chk("small_dec_done", s_done, 1'b1);
    chk("small_dec_dout", s_data_out, 8'h0F);

    // Randomised encrypt / decrypt round trips.
    for (int t = 0; t < 6; t++) begin
      pt = {$urandom, $urandom};
      k  = rand_key();
      do_op("enc", 1'b0, pt, k, t == 2, ct);
      do_op("dec", 1'b1, ct, k, t == 3, rt);
      chk("roundtrip", rt, pt);
    end

    // Zero key is rejected.
    @(negedge clk);
    start = 1'b1; key = '0; data_in = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    chk("zkey_err", err, 1'b1);
    chk("zkey_busy", busy, 1'b0);
    chk("zkey_dout_held", data_out, rt);
    @(negedge clk);
    chk("zkey_err_pulse", err, 1'b0);
    count_done("zkey_no_done", 15);

    // Abort at cycle 5 of RUN.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; key = rand_key(); data_in = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort5_busy", busy, 1'b0);
    chk("abort5_dout", data_out, '0);
    chk("abort5_done", done, 1'b0);
    count_done("abort5_no_done", 15);

    // Refill data_out, then abort on the final round edge.
    pt = {$urandom, $urandom};
    k  = rand_key();
    do_op("pre_abort10", 1'b0, pt, k, 1'b0, ct);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; key = k; data_in = ct;
    @(negedge clk);
    start = 1'b0;
    repeat (NR - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort10_done", done, 1'b0);
    chk("abort10_dout", data_out, '0);
    chk("abort10_busy", busy, 1'b0);
    count_done("abort10_no_done", 15);

    // Abort and start together in IDLE: abort wins, data_out cleared.
    do_op("pre_idle_abort", 1'b0, pt, k, 1'b0, ct);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; key = k;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);
    chk("idle_abort_err", err, 1'b0);
    chk("idle_abort_dout", data_out, '0);
    count_done("idle_abort_no_done", 15);

    // Reset at cycle 3 of RUN; first edge after release accepts a start.
    do_op("pre_reset", 1'b0, pt, k, 1'b0, ct);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; key = k; data_in = pt;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_dout", data_out, '0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_key", u_dut.key_q, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_busy", busy, 1'b0);
    pt = {$urandom, $urandom};
    do_op("after_rst", 1'b0, pt, k, 1'b0, ct);
    do_op("after_rst_dec", 1'b1, ct, k, 1'b0, rt);
    chk("after_rst_roundtrip", rt, pt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
